// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode values, ALU control codes and the DECODE dispatch rule.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_I_WB     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Instruction-class dispatch out of DECODE; unknown opcodes trap.
  function automatic state_t decode_next(input logic [3:0] opcode);
    state_t nxt;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: nxt = ST_EXEC_R;
      OP_ADDI:                               nxt = ST_EXEC_I;
      OP_LW, OP_SW:                          nxt = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                        nxt = ST_BRANCH;
      default:                               nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Maps the latched R-type opcode onto the ALU operation used in EXEC_R.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_ctl_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (opcode_i)
      OP_ADD:  alu_ctl_o = ALU_ADD;
      OP_SUB:  alu_ctl_o = ALU_SUB;
      OP_AND:  alu_ctl_o = ALU_AND;
      OP_OR:   alu_ctl_o = ALU_OR;
      OP_SLT:  alu_ctl_o = ALU_SLT;
      default: alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE followed by per-class
// execute, memory and writeback states, with a sticky trap on bad opcodes.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       pc_source,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctl,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic [2:0] r_alu_ctl;

  mc_alu_decode u_alu_decode (
    .opcode_i  (op_q),
    .alu_ctl_o (r_alu_ctl)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= op;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_source  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_ctl    = ALU_AND;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_TWO;
        alu_ctl   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_ctl   = ALU_ADD;
        state_d   = decode_next(op);
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctl   = r_alu_ctl;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = ALU_ADD;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = ALU_ADD;
        state_d   = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctl   = ALU_SUB;
        pc_source = 1'b1;
        retire    = 1'b1;
        pc_write  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
        state_d = ST_TRAP;
      end
      default: state_d = ST_TRAP;
    endcase

    // The FETCH enables are combinational on mem_ready; keep them quiet in reset.
    if (!resetn) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized + directed check of multicycle_control against a
// per-instruction expected-cycle queue built from the instruction class.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, pc_source, retire, illegal;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  multicycle_control dut (
    .clock(clock), .resetn(resetn), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_source(pc_source),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .state(state), .retire(retire),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcw, irw, iod, mrd, mwr, m2r, rdst, rw, asa, pcs;
    logic [1:0] asb;
    logic [2:0] actl;
    logic [3:0] st;
    logic       ret, ill;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       mr;
    logic       rn;
    outs_t      e;
    string      tag;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic outs_t fetch_o(input logic fire);
    outs_t e = '0;
    e.mrd = 1'b1; e.asb = 2'b01; e.actl = 3'b010;
    e.irw = fire; e.pcw = fire;
    return e;
  endfunction

  function automatic logic [2:0] r_alu(input logic [3:0] o);
    case (o)
      4'd0: return 3'b010;
      4'd1: return 3'b110;
      4'd2: return 3'b000;
      4'd3: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic push(input logic [3:0] o, input logic z, input logic mr,
                      input logic rn, input outs_t e, input string tag);
    cyc_t c;
    c.op = o; c.z = z; c.mr = mr; c.rn = rn; c.e = e; c.tag = tag;
    q.push_back(c);
  endtask

  task automatic push_reset(input string tag);
    push(rop(), rbit(), rbit(), 1'b0, fetch_o(1'b0), tag);
  endtask

  // Expected cycles of one instruction: fst fetch stalls, mst memory stalls
  // (or trap cycles), branch zero flag zv; rst_mid resets inside a memory stall.
  task automatic gen_instr(input logic [3:0] opc, input int fst, input int mst,
                           input logic zv, input logic rst_mid);
    outs_t e;
    for (int i = 0; i < fst; i++) push(rop(), rbit(), 1'b0, 1'b1, fetch_o(1'b0), "fetch_stall");
    push(rop(), rbit(), 1'b1, 1'b1, fetch_o(1'b1), "fetch");
    e = '0; e.st = 4'd1; e.asb = 2'b11; e.actl = 3'b010;
    push(opc, rbit(), rbit(), 1'b1, e, "decode");
    if (opc inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) begin
      e = '0; e.st = 4'd2; e.asa = 1'b1; e.asb = 2'b00; e.actl = r_alu(opc);
      push(rop(), rbit(), rbit(), 1'b1, e, "exec_r");
      e = '0; e.st = 4'd3; e.rdst = 1'b1; e.rw = 1'b1; e.ret = 1'b1;
      push(rop(), rbit(), rbit(), 1'b1, e, "r_wb");
    end else if (opc == 4'd4) begin
      e = '0; e.st = 4'd4; e.asa = 1'b1; e.asb = 2'b10; e.actl = 3'b010;
      push(rop(), rbit(), rbit(), 1'b1, e, "exec_i");
      e = '0; e.st = 4'd5; e.rw = 1'b1; e.ret = 1'b1;
      push(rop(), rbit(), rbit(), 1'b1, e, "i_wb");
    end else if (opc == 4'd5 || opc == 4'd6) begin
      e = '0; e.st = 4'd6; e.asa = 1'b1; e.asb = 2'b10; e.actl = 3'b010;
      push(rop(), rbit(), rbit(), 1'b1, e, "mem_addr");
      e = '0; e.iod = 1'b1;
      if (opc == 4'd5) begin e.st = 4'd7; e.mrd = 1'b1; end
      else begin e.st = 4'd9; e.mwr = 1'b1; end
      for (int i = 0; i < mst; i++) push(rop(), rbit(), 1'b0, 1'b1, e, "mem_stall");
      if (rst_mid && mst > 0) begin
        push_reset("reset_mid");
        return;
      end
      if (opc == 4'd6) e.ret = 1'b1;
      push(rop(), rbit(), 1'b1, 1'b1, e, "mem_access");
      if (opc == 4'd5) begin
        e = '0; e.st = 4'd8; e.m2r = 1'b1; e.rw = 1'b1; e.ret = 1'b1;
        push(rop(), rbit(), rbit(), 1'b1, e, "mem_wb");
      end
    end else if (opc == 4'd8 || opc == 4'd9) begin
      e = '0; e.st = 4'd10; e.asa = 1'b1; e.asb = 2'b00; e.actl = 3'b110;
      e.pcs = 1'b1; e.ret = 1'b1;
      e.pcw = (opc == 4'd8) ? zv : ~zv;
      push(rop(), zv, rbit(), 1'b1, e, "branch");
    end else begin
      e = '0; e.st = 4'd15; e.ill = 1'b1;
      for (int i = 0; i < mst; i++) push(rop(), rbit(), rbit(), 1'b1, e, "trap");
      push_reset("trap_reset");
    end
  endtask

  initial begin
    #2000000;
    if (!done) begin
      errors++;
      $error("FAIL watchdog expired with %0d cycles pending", q.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [3:0] legal [10];
    outs_t      obs;
    cyc_t       c;
    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    resetn = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b1;

    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || mem_read !== 1'b1 ||
        alu_src_b !== 2'b01 || alu_ctl !== 3'b010 || ir_write !== 1'b0 ||
        pc_write !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0 ||
        retire !== 1'b0) begin
      errors++;
      $error("FAIL reset_state state=%h illegal=%b mem_read=%b alu_src_b=%b alu_ctl=%b ir_write=%b pc_write=%b",
             state, illegal, mem_read, alu_src_b, alu_ctl, ir_write, pc_write);
    end
    $display("cycle %0d reset_state state=%h illegal=%b", checks, state, illegal);

    push_reset("reset");
    gen_instr(4'd0, 0, 0, 1'b0, 1'b0);
    gen_instr(4'd5, 0, 2, 1'b0, 1'b0);
    gen_instr(4'd8, 0, 0, 1'b1, 1'b0);
    gen_instr(4'd9, 0, 0, 1'b1, 1'b0);
    gen_instr(4'd0, 3, 0, 1'b0, 1'b0);
    gen_instr(4'd6, 0, 2, 1'b0, 1'b1);
    gen_instr(4'd15, 0, 20, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] opc;
      if ($urandom_range(0, 11) < 10) opc = legal[$urandom_range(0, 9)];
      else opc = 4'($urandom_range(10, 15));
      gen_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)) + (opc >= 4'd10 ? 1 : 0),
                rbit(), ($urandom_range(0, 7) == 0));
    end

    @(posedge clock); #1;
    while (q.size() > 0) begin
      c = q.pop_front();
      resetn = c.rn; op = c.op; zero = c.z; mem_ready = c.mr;
      #1;
      obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, pc_source, alu_src_b, alu_ctl, state, retire, illegal};
      checks++;
      assert (obs === c.e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.e);
      end
      $display("cycle %0d %s rn=%b op=%h z=%b mr=%b out=%h", checks, c.tag, c.rn, c.op, c.z, c.mr, obs);
      @(posedge clock); #1;
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
